// File: rtl/isqrt_rr_share_if.sv
// isqrt_rr_share_if
//   Groups the handshake and data signals that run between two requesters,
//   the shared-isqrt arbiter and the pipelined isqrt unit.
//
//   Requester N (N = 0, 1):
//     reqN_x_vld  operand valid                 (requester -> arbiter)
//     reqN_x      32-bit operand                (requester -> arbiter)
//     reqN_x_rdy  operand accepted this cycle   (arbiter -> requester)
//     reqN_y_vld  result valid, one-cycle pulse (arbiter -> requester)
//     reqN_y      16-bit result                 (arbiter -> requester)
//   isqrt unit:
//     isqrt_x_vld operand valid                 (arbiter -> isqrt)
//     isqrt_x     32-bit operand                (arbiter -> isqrt)
//     isqrt_y_vld result valid                  (isqrt -> arbiter)
//     isqrt_y     16-bit result                 (isqrt -> arbiter)
//
//   slave  : the arbiter's view.
//   master : the view of the surrounding requesters and isqrt unit.
interface isqrt_rr_share_if;
  logic        req0_x_vld;
  logic [31:0] req0_x;
  logic        req0_x_rdy;
  logic        req0_y_vld;
  logic [15:0] req0_y;

  logic        req1_x_vld;
  logic [31:0] req1_x;
  logic        req1_x_rdy;
  logic        req1_y_vld;
  logic [15:0] req1_y;

  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld;
  logic [15:0] isqrt_y;

  modport slave (
    input  req0_x_vld, req0_x,
    output req0_x_rdy, req0_y_vld, req0_y,
    input  req1_x_vld, req1_x,
    output req1_x_rdy, req1_y_vld, req1_y,
    output isqrt_x_vld, isqrt_x,
    input  isqrt_y_vld, isqrt_y
  );

  modport master (
    output req0_x_vld, req0_x,
    input  req0_x_rdy, req0_y_vld, req0_y,
    output req1_x_vld, req1_x,
    input  req1_x_rdy, req1_y_vld, req1_y,
    input  isqrt_x_vld, isqrt_x,
    output isqrt_y_vld, isqrt_y
  );
endinterface

// File: rtl/isqrt_rr_share.sv
// isqrt_rr_share
//   Shares one pipelined, in-order isqrt unit between two requesters.
//   Operands are arbitrated round-robin and forwarded to the isqrt unit with
//   no added latency; the winning requester's ID is pushed into a tag FIFO.
//   Because the isqrt unit returns results in issue order, each returning
//   result pops the head tag and is steered (registered) to that requester.
//
// Parameters:
//   MAX_OUT     maximum requests in flight (power of 2, 2..64); tag FIFO depth
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   bus         isqrt_rr_share_if.slave: requester and isqrt handshakes
//   outstanding number of requests currently in flight
//   proto_err   sticky: a result arrived while no request was in flight
module isqrt_rr_share #(
  parameter int MAX_OUT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  isqrt_rr_share_if.slave           bus,
  output logic [$clog2(MAX_OUT):0]  outstanding,
  output logic                      proto_err
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  logic               full;
  logic               empty;
  logic               grant0;
  logic               grant1;
  logic               push;
  logic               pop;
  logic               head_id;
  logic               last_grant;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [MAX_OUT-1:0] tag_mem;

  // Full is judged on the registered count only, so a pop in this cycle
  // frees its slot starting next cycle.
  assign full  = (outstanding == CW'(MAX_OUT));
  assign empty = (outstanding == '0);

  // On a tie the requester that did not win last time is granted;
  // last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!full) begin
      if (bus.req0_x_vld && bus.req1_x_vld) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_x_vld;
        grant1 = bus.req1_x_vld;
      end
    end
  end

  assign push            = grant0 | grant1;
  assign pop             = bus.isqrt_y_vld && !empty;
  assign head_id         = tag_mem[rd_ptr];

  assign bus.req0_x_rdy  = grant0;
  assign bus.req1_x_rdy  = grant1;
  assign bus.isqrt_x_vld = push;
  assign bus.isqrt_x     = grant1 ? bus.req1_x : bus.req0_x;

  // Tag storage holds only valid entries between rd_ptr and wr_ptr, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant1;
    end
  end

  // Pointers wrap naturally because MAX_OUT is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      last_grant  <= 1'b1;
      proto_err   <= 1'b0;
      bus.req0_y_vld <= 1'b0;
      bus.req1_y_vld <= 1'b0;
      bus.req0_y     <= '0;
      bus.req1_y     <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        last_grant <= grant1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      bus.req0_y_vld <= pop && !head_id;
      bus.req1_y_vld <= pop && head_id;
      if (pop && !head_id) begin
        bus.req0_y <= bus.isqrt_y;
      end
      if (pop && head_id) begin
        bus.req1_y <= bus.isqrt_y;
      end

      // A result with nothing in flight cannot be routed; it is dropped.
      if (bus.isqrt_y_vld && empty) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/isqrt_rr_share.md
Name: isqrt_rr_share

Overview:
- Shares one pipelined, in-order isqrt instance between two independent requesters, for example two formula FSMs.
- Arbitrates round-robin on the request side and keeps a tag FIFO of requester IDs, so each isqrt result is returned to the requester that issued it.
- Sits between formula controllers and the isqrt unit, in place of a dedicated isqrt per controller.

Parameters:
- MAX_OUT, 8, maximum number of requests in flight inside the isqrt unit; power of 2, range 2..64; sets the tag FIFO depth.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req0_x_vld  in  1  requester 0 operand valid
- req0_x  in  32  requester 0 operand
- req0_x_rdy  out  1  requester 0 operand accepted this cycle (combinational)
- req0_y_vld  out  1  requester 0 result valid (registered)
- req0_y  out  16  requester 0 result
- req1_x_vld  in  1  requester 1 operand valid
- req1_x  in  32  requester 1 operand
- req1_x_rdy  out  1  requester 1 operand accepted this cycle
- req1_y_vld  out  1  requester 1 result valid
- req1_y  out  16  requester 1 result
- isqrt_x_vld  out  1  operand valid to the isqrt unit
- isqrt_x  out  32  operand to the isqrt unit
- isqrt_y_vld  in  1  isqrt result valid
- isqrt_y  in  16  isqrt result
- outstanding  out  $clog2(MAX_OUT)+1  number of requests in flight
- proto_err  out  1  sticky flag: result arrived with the tag FIFO empty

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - FIFO emptied, outstanding=0, proto_err=0.
  - req0_y_vld=0, req1_y_vld=0, req0_y=0, req1_y=0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - The isqrt unit is reset by the same rst; reset mid-operation discards all in-flight tags without error.
- Arbitration (combinational):
  - full = (outstanding == MAX_OUT).
  - If full, both rdy=0 and isqrt_x_vld=0. A pop in the same cycle does not free a slot until the next cycle.
  - Else, if only one requester is valid, that requester is granted.
  - Else, if both are valid, the requester that is not last_grant is granted.
  - rdy of the granted requester is 1; the other rdy is 0. rdy is 0 whenever the requester's own vld is 0.
  - isqrt_x_vld = any grant; isqrt_x = the granted requester's x. isqrt_x is don't-care when there is no grant.
  - last_grant updates to the granted ID on each accept and holds otherwise.
- Issue:
  - An accept pushes the granted ID (1 bit) into the tag FIFO; zero added latency on the request path.
  - Throughput is one request per cycle.
- Return:
  - When isqrt_y_vld=1 and the FIFO is non-empty, pop the head ID.
  - The next cycle, reqID_y_vld=1 and reqID_y=isqrt_y; the other requester's y_vld=0. Return latency is the isqrt latency + 1.
  - reqN_y holds its last value when not valid.
  - No backpressure on results: requesters must always accept them.
- Counting:
  - outstanding = pushes - pops.
  - Simultaneous push and pop leaves outstanding unchanged; allowed whenever not full.
  - FIFO pointers wrap modulo MAX_OUT.
- Error:
  - isqrt_y_vld with the FIFO empty: no pop, no y_vld, outstanding unchanged, proto_err set to 1 until rst.
- Ordering:
  - Results to each requester arrive in that requester's issue order.
  - Global return order equals global accept order.

Test Plan:
- Bench uses an isqrt model: pipelined, latency 4, accepts every cycle.
- Single requester: req0 sends x=144,25,0 back-to-back -> req0_x_rdy=1 each cycle; req0_y_vld 5 cycles after each send with y=12,5,0; req1_y_vld never asserts.
- Tie after reset: both valid, req0_x=49, req1_x=81 held -> cycle 0 grants req0, cycle 1 grants req1; req0_y=7, then req1_y=9 one cycle later; alternation continues while both stay valid.
- Full: MAX_OUT=8, isqrt model stalled (no y_vld), req0 streams 10 requests -> 8 accepted, rdy=0 with outstanding=8. Release one result -> rdy returns to 1 the cycle after the pop.
- Simultaneous push and pop at outstanding=3 -> outstanding stays 3; routing remains correct over 100 random interleaved requests checked against a scoreboard (y=floor(sqrt(x)), including x=32'hFFFFFFFF -> 65535).
- Spurious result: inject isqrt_y_vld with outstanding=0 -> proto_err=1 next cycle and stays 1; no reqN_y_vld pulse.
- Reset mid-stream with 5 outstanding -> next cycle outstanding=0, proto_err=0, both y_vld=0; next tie grants req0.
